// File: rtl/roi_stats.sv
// rtl/roi_stats.sv - per-frame pixel count/sum/min/max engine with APB shadow registers (option: ROI_STATS_IRQ_EN)
module roi_stats #(
    parameter int BIT_D = 8,
    parameter int BIT_C = 32,
    parameter int BIT_A = 3
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [BIT_D-1:0] tdata_i,
    input  logic             tvalid_i,
    input  logic             tlast_i,
    input  logic [BIT_A-1:0] apb_paddr_i,
    input  logic [BIT_C-1:0] apb_pwdata_i,
    input  logic             apb_pwrite_i,
    input  logic             apb_psel_i,
    input  logic             apb_penable_i,
    output logic [BIT_C-1:0] apb_prdata_o,
    output logic             apb_pready_o,
    output logic             apb_pslverr_o,
    output logic             frame_done_o
`ifdef ROI_STATS_IRQ_EN
    ,
    output logic             irq_o
`endif
);

    localparam logic [BIT_C-1:0] C_MAX = {BIT_C{1'b1}};
    localparam logic [BIT_D-1:0] D_MAX = {BIT_D{1'b1}};

    localparam logic [BIT_A-1:0] IDX_CTRL   = BIT_A'(0);
    localparam logic [BIT_A-1:0] IDX_COUNT  = BIT_A'(1);
    localparam logic [BIT_A-1:0] IDX_SUM    = BIT_A'(2);
    localparam logic [BIT_A-1:0] IDX_MINMAX = BIT_A'(3);
    localparam logic [BIT_A-1:0] IDX_FRAMES = BIT_A'(4);
    localparam logic [BIT_A-1:0] IDX_STATUS = BIT_A'(5);

    logic             ctrl_en;
    logic             ctrl_mask;
    logic [BIT_C-1:0] cnt, sum;
    logic [BIT_D-1:0] mn, mx;
    logic [BIT_C-1:0] sh_cnt, sh_sum, frames;
    logic [BIT_D-1:0] sh_min, sh_max;
    logic             irq_pend;

    logic             beat_acc, frame_end;
    logic             wr_access, rd_setup, ctrl_wr, status_clr, discard;
    logic [BIT_C-1:0] cnt_nx, sum_nx;
    logic [BIT_C:0]   sum_wide;
    logic [BIT_D-1:0] min_nx, max_nx;
    logic [BIT_C-1:0] rd_val;
    logic             unused_pwdata;

    assign beat_acc   = tvalid_i & ctrl_en;
    assign frame_end  = beat_acc & tlast_i;
    assign wr_access  = apb_psel_i & apb_penable_i & apb_pwrite_i;
    assign rd_setup   = apb_psel_i & ~apb_penable_i & ~apb_pwrite_i;
    assign ctrl_wr    = wr_access & (apb_paddr_i == IDX_CTRL);
    assign status_clr = wr_access & (apb_paddr_i == IDX_STATUS) & apb_pwdata_i[0];
    // Only a 1->0 transition of enable throws away the frame in flight.
    assign discard    = ctrl_wr & ctrl_en & ~apb_pwdata_i[0];

    assign unused_pwdata = ^apb_pwdata_i;

    // Saturating next values for the live accumulators, including the current pixel.
    always_comb begin
        cnt_nx   = (cnt == C_MAX) ? cnt : cnt + 1'b1;
        sum_wide = {1'b0, sum} + {{(BIT_C + 1 - BIT_D){1'b0}}, tdata_i};
        sum_nx   = sum_wide[BIT_C] ? C_MAX : sum_wide[BIT_C-1:0];
        min_nx   = (tdata_i < mn) ? tdata_i : mn;
        max_nx   = (tdata_i > mx) ? tdata_i : mx;
    end

    // Control register: enable, plus the interrupt mask when that option is built.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            ctrl_en <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en <= apb_pwdata_i[0];
        end
    end

`ifdef ROI_STATS_IRQ_EN
    // Interrupt mask-enable bit of CTRL.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            ctrl_mask <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_mask <= apb_pwdata_i[1];
        end
    end

    assign irq_o = irq_pend & ctrl_mask;
`else
    assign ctrl_mask = 1'b0;
`endif

    // Live accumulators: restart on frame end, on disable and on reset.
    always_ff @(posedge clk_i) begin
        if (arst_i || discard || frame_end) begin
            cnt <= '0;
            sum <= '0;
            mn  <= D_MAX;
            mx  <= '0;
        end else if (beat_acc) begin
            cnt <= cnt_nx;
            sum <= sum_nx;
            mn  <= min_nx;
            mx  <= max_nx;
        end
    end

    // Snapshot shadows and the completed-frame counter, loaded on the tlast beat.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            sh_cnt <= '0;
            sh_sum <= '0;
            sh_min <= D_MAX;
            sh_max <= '0;
            frames <= '0;
        end else if (frame_end) begin
            sh_cnt <= cnt_nx;
            sh_sum <= sum_nx;
            sh_min <= min_nx;
            sh_max <= max_nx;
            frames <= frames + 1'b1;
        end
    end

    // Pending flag: a completing frame wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            irq_pend <= 1'b0;
        end else if (frame_end) begin
            irq_pend <= 1'b1;
        end else if (status_clr) begin
            irq_pend <= 1'b0;
        end
    end

    // One-cycle completion pulse following the tlast edge.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
        end
    end

    // Register read mux; unmapped indices read as zero.
    always_comb begin
        rd_val = '0;
        case (apb_paddr_i)
            IDX_CTRL: begin
                rd_val[0] = ctrl_en;
                rd_val[1] = ctrl_mask;
            end
            IDX_COUNT:  rd_val = sh_cnt;
            IDX_SUM:    rd_val = sh_sum;
            IDX_MINMAX: rd_val[2*BIT_D-1:0] = {sh_max, sh_min};
            IDX_FRAMES: rd_val = frames;
            IDX_STATUS: rd_val[0] = irq_pend;
            default:    rd_val = '0;
        endcase
    end

    // Read data is captured in the setup phase and held through the access phase.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            apb_prdata_o <= '0;
        end else if (rd_setup) begin
            apb_prdata_o <= rd_val;
        end
    end

    assign apb_pready_o  = 1'b1;
    assign apb_pslverr_o = apb_psel_i & apb_penable_i & (apb_paddr_i > IDX_STATUS);

endmodule

// File: tb/tb_roi_stats.sv
// tb/tb_roi_stats.sv - randomized self-checking bench for roi_stats against a frame-level model
module tb_roi_stats;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  tdata;
    logic        tvalid, tlast;
    logic [2:0]  paddr;
    logic [31:0] pwdata;
    logic        pwrite, psel, penable;
    logic [31:0] prdata;
    logic        pready, pslverr, frame_done;
`ifdef ROI_STATS_IRQ_EN
    logic        irq;
`endif

    roi_stats dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .tdata_i       (tdata),
        .tvalid_i      (tvalid),
        .tlast_i       (tlast),
        .apb_paddr_i   (paddr),
        .apb_pwdata_i  (pwdata),
        .apb_pwrite_i  (pwrite),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr),
        .frame_done_o  (frame_done)
`ifdef ROI_STATS_IRQ_EN
        ,
        .irq_o         (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level reference model
    int          q[$];
    logic [31:0] m_cnt, m_sum, m_frames;
    logic [7:0]  m_min, m_max;
    bit          m_en, m_mask, m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_sum = 0; m_frames = 0;
        m_min = 8'hFF; m_max = 8'h00;
        m_en = 0; m_mask = 0; m_irq = 0;
    endtask

    task automatic model_snap();
        longint s = 0;
        int mn = 255;
        int mx = 0;
        foreach (q[i]) begin
            s += q[i];
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
        end
        m_cnt = q.size();
        m_sum = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
        m_min = 8'(mn);
        m_max = 8'(mx);
        m_frames = m_frames + 1;
        m_irq = 1;
        q.delete();
    endtask

    task automatic model_beat(input logic [7:0] d, input logic l);
        if (m_en) begin
            q.push_back(int'(d));
            if (l) model_snap();
        end
    endtask

    task automatic model_wr(input logic [2:0] idx, input logic [31:0] d);
        if (idx == 3'd0) begin
            if (m_en && !d[0]) q.delete();
            m_en = d[0];
`ifdef ROI_STATS_IRQ_EN
            m_mask = d[1];
`endif
        end else if (idx == 3'd5 && d[0]) begin
            m_irq = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq();
`ifdef ROI_STATS_IRQ_EN
        chk("irq_o", irq, m_irq & m_mask);
`endif
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        bit exp_fd;
        exp_fd = l & m_en;
        tvalid = 1; tdata = d; tlast = l;
        tick();
        model_beat(d, l);
        chk("frame_done", frame_done, exp_fd);
        chk_irq();
    endtask

    task automatic idle(input int n);
        tvalid = 0; tlast = 0;
        repeat (n) begin
            tick();
            chk("frame_done_idle", frame_done, 0);
            chk_irq();
        end
    endtask

    task automatic apb_wr(input logic [2:0] idx, input logic [31:0] d, output logic err);
        tvalid = 0; tlast = 0;
        psel = 1; pwrite = 1; penable = 0; paddr = idx; pwdata = d;
        tick();
        penable = 1;
        #1 err = pslverr;
        tick();
        psel = 0; penable = 0; pwrite = 0;
        model_wr(idx, d);
    endtask

    task automatic apb_rd(input logic [2:0] idx, output logic [31:0] d, output logic err);
        tvalid = 0; tlast = 0;
        psel = 1; pwrite = 0; penable = 0; paddr = idx;
        tick();
        penable = 1;
        #1;
        d = prdata;
        err = pslverr;
        tick();
        psel = 0; penable = 0;
    endtask

    task automatic rd_chk(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic e;
        apb_rd(idx, d, e);
        chk(tag, d, exp);
        chk({tag, "_err"}, e, 0);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        logic e;
        apb_wr(idx, d, e);
        chk($sformatf("wr%0d_err", idx), e, 0);
    endtask

    task automatic check_all(input string pfx);
        rd_chk(3'd0, {30'b0, m_mask, m_en}, {pfx, "_ctrl"});
        rd_chk(3'd1, m_cnt, {pfx, "_count"});
        rd_chk(3'd2, m_sum, {pfx, "_sum"});
        rd_chk(3'd3, {16'h0, m_max, m_min}, {pfx, "_minmax"});
        rd_chk(3'd4, m_frames, {pfx, "_frames"});
        rd_chk(3'd5, {31'b0, m_irq}, {pfx, "_status"});
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] old_cnt;
        int          len;

        arst = 1; tdata = 0; tvalid = 0; tlast = 0;
        paddr = 0; pwdata = 0; pwrite = 0; psel = 0; penable = 0;
        model_reset();
        repeat (3) tick();
        arst = 0;

        // Reset state
        chk("rst_prdata", prdata, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pready", pready, 1);
        check_all("rst");

        // Disabled: beats including tlast are ignored
        beat(8'd7, 0); beat(8'd7, 1); idle(2);
        check_all("dis");

        // Basic frame 10,20,30,40
        wr(3'd0, 32'h1);
        beat(8'd10, 0); beat(8'd20, 0); beat(8'd30, 0); beat(8'd40, 1); idle(3);
        check_all("f1");
        chk("f1_count_const", m_cnt, 4);
        chk("f1_sum_const", m_sum, 100);

        // Back-to-back frames {5} and {255,0}
        beat(8'd5, 1); beat(8'd255, 0); beat(8'd0, 1); idle(1);
        check_all("b2b");

        // Disable mid-frame, re-enable, frame {1,2}
        beat(8'd9, 0); beat(8'd9, 0); beat(8'd9, 0);
        wr(3'd0, 32'h0);
        wr(3'd0, 32'h1);
        beat(8'd1, 0); beat(8'd2, 1); idle(1);
        check_all("disc");

        // CTRL bit1 only sticks when the interrupt option is built
        wr(3'd0, 32'h3);
        rd_chk(3'd0, {30'b0, m_mask, m_en}, "ctrl_b1");

        // Invalid index reads and writes; RO writes ignored
        apb_rd(3'd6, d, e);
        chk("rd6_data", d, 0);
        chk("rd6_err", e, 1);
        apb_rd(3'd7, d, e);
        chk("rd7_err", e, 1);
        apb_wr(3'd7, 32'hFFFF_FFFF, e);
        chk("wr7_err", e, 1);
        wr(3'd1, 32'h1234);
        wr(3'd4, 32'h55);
        check_all("ro");

`ifdef ROI_STATS_IRQ_EN
        chk("irq_masked_on", irq, m_irq & m_mask);
`endif
        // Clear pending, then clear on the same edge as a frame's tlast
        wr(3'd5, 32'h1);
        rd_chk(3'd5, 0, "clr");
        psel = 1; pwrite = 1; penable = 0; paddr = 3'd5; pwdata = 32'h1;
        tvalid = 1; tdata = 8'd9; tlast = 0;
        tick();
        model_beat(8'd9, 0);
        penable = 1; tdata = 8'd11; tlast = 1;
        tick();
        model_wr(3'd5, 32'h1);
        model_beat(8'd11, 1);
        chk("race_fd", frame_done, 1);
        psel = 0; penable = 0; pwrite = 0;
        idle(1);
        check_all("race");

        // Setup capture on the same edge as a shadow update returns the old value
        old_cnt = m_cnt;
        psel = 1; pwrite = 0; penable = 0; paddr = 3'd1;
        tvalid = 1; tdata = 8'd50; tlast = 1;
        tick();
        model_beat(8'd50, 1);
        penable = 1; tvalid = 0; tlast = 0;
        #1 chk("setup_old", prdata, old_cnt);
        tick();
        psel = 0; penable = 0;
        rd_chk(3'd1, m_cnt, "setup_new");

        // Interrupt output gating
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h1);
        beat(8'd4, 1); idle(2);
        wr(3'd0, 32'h3);
        idle(1);
        wr(3'd5, 32'h1);
        beat(8'd6, 0); beat(8'd8, 1); idle(2);
        wr(3'd5, 32'h1);
        idle(1);
        check_all("irq");

        // Reset mid-frame, then frame {3}
        beat(8'd100, 0); beat(8'd100, 0);
        arst = 1; tvalid = 0; tlast = 0;
        tick(); tick();
        arst = 0;
        model_reset();
        chk("rst2_prdata", prdata, 0);
        chk("rst2_fd", frame_done, 0);
        wr(3'd0, 32'h1);
        beat(8'd3, 1); idle(1);
        check_all("rst2");

        // Random frames with gaps and back-to-back starts
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                beat(8'($urandom_range(0, 255)), i == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 1) == 0) begin
                idle($urandom_range(1, 3));
                check_all($sformatf("rnd%0d", f));
            end
        end
        idle(1);
        check_all("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
